// File: rtl/note_sequencer_if.sv
// Note ROM bus between the sequencer (master drives the address) and the registered note ROM.
interface note_sequencer_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_note;

  modport master (output rom_addr, input rom_note);
  modport slave  (input rom_addr, output rom_note);
endinterface

// File: rtl/note_sequencer.sv
// Note ROM playback controller: fetches 8-bit codes, emits held MIDI note + gate per step.
// Optional NOTE_SEQ_LEGATO_EN removes the end-of-step articulation gap between sounding steps.
module note_sequencer #(
  parameter int unsigned TICK_DIV   = 6250000,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_en_i,
  note_sequencer_if.master rom,
  output logic [6:0]       note_o,
  output logic             gate_o,
  output logic             step_strobe_o,
  output logic             playing_o,
  output logic             done_o
);

`ifdef NOTE_SEQ_LEGATO_EN
  localparam bit LegatoEn = 1'b1;
`else
  localparam bit LegatoEn = 1'b0;
`endif

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  // FETCH + EVAL take two cycles of each step period; HOLD covers the rest.
  localparam logic [CntW-1:0] HoldLoad = CntW'(TICK_DIV - 3);
  localparam int unsigned GapThr = (GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0;

  typedef enum logic [1:0] {StIdle, StFetch, StEval, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        note_q, note_d;
  logic              gate_q, gate_d;
  logic              strobe_q, strobe_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      note_q   <= '0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;
    cnt_d    = cnt_q;
    done_o   = 1'b0;

    if (stop_i) begin
      state_d = StIdle;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StFetch;
            addr_d  = '0;
          end
        end
        StFetch: begin
          state_d = StEval;
          // A single-cycle gap lands on FETCH; longer gaps already dropped gate in HOLD.
          if (!LegatoEn && GAP_CYCLES >= 1) gate_d = 1'b0;
        end
        StEval: begin
          cnt_d = HoldLoad;
          if (rom.rom_note == 8'd0) begin
            if (loop_en_i) begin
              addr_d  = '0;
              state_d = StFetch;
            end else begin
              gate_d  = 1'b0;
              done_o  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            strobe_d = 1'b1;
            state_d  = StHold;
            if (rom.rom_note[7]) begin
              gate_d = 1'b0;
            end else begin
              note_d = rom.rom_note[6:0];
              gate_d = 1'b1;
            end
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StFetch;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
          if (!LegatoEn && GAP_CYCLES >= 2 && 32'(cnt_q) <= GapThr) gate_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rom.rom_addr  = addr_q;
  assign note_o        = note_q;
  assign gate_o        = gate_q;
  assign step_strobe_o = strobe_q;
  assign playing_o     = (state_q != StIdle);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer with a registered ROM stub (TICK_DIV=8, GAP=2).
module tb_note_sequencer;

`ifdef NOTE_SEQ_LEGATO_EN
  localparam bit Legato = 1'b1;
`else
  localparam bit Legato = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop, loop_en;
  logic [6:0] note;
  logic       gate, strobe, playing, done;
  logic [7:0] mem [512];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;

  note_sequencer_if #(.ADDR_W(9)) rom_if ();

  note_sequencer #(
    .TICK_DIV  (8),
    .GAP_CYCLES(2),
    .ADDR_W    (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .stop_i       (stop),
    .loop_en_i    (loop_en),
    .rom          (rom_if.master),
    .note_o       (note),
    .gate_o       (gate),
    .step_strobe_o(strobe),
    .playing_o    (playing),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_if.rom_note <= mem[rom_if.rom_addr];

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Start is held during the cycle labelled 0; returns positioned in cycle 1.
  task automatic start_play();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) begin
      tick();
      if (strobe) strobes++;
    end
  endtask

  initial begin
    logic e_gate;
    logic [6:0] e_note;
    logic [8:0] e_addr;

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    foreach (mem[i]) mem[i] = 8'd0;
    mem[0] = 8'd76; mem[1] = 8'd255; mem[2] = 8'd72; mem[3] = 8'd0;
    tick(); tick();
    check("rst_addr", 32'(rom_if.rom_addr), 32'(0));
    check("rst_note", 32'(note), 32'(0));
    check("rst_gate", 32'(gate), 32'(0));
    check("rst_strobe", 32'(strobe), 32'(0));
    check("rst_playing", 32'(playing), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    tick();

    // Play once to the end code.
    start_play();
    for (int c = 1; c <= 30; c++) begin
      if (Legato) e_gate = (c >= 3 && c <= 10) || (c >= 19 && c <= 26);
      else        e_gate = (c >= 3 && c <= 8)  || (c >= 19 && c <= 24);
      e_note = (c < 3) ? 7'd0 : (c < 19) ? 7'd76 : 7'd72;
      e_addr = (c < 9) ? 9'd0 : (c < 17) ? 9'd1 : (c < 25) ? 9'd2 : 9'd3;
      check("once_strobe", 32'(strobe), 32'(c == 3 || c == 11 || c == 19));
      check("once_gate", 32'(gate), 32'(e_gate));
      check("once_note", 32'(note), 32'(e_note));
      check("once_addr", 32'(rom_if.rom_addr), 32'(e_addr));
      check("once_done", 32'(done), 32'(c == 26));
      check("once_playing", 32'(playing), 32'(c <= 26));
      tick();
    end

    // Loop mode, then stop during a sounding HOLD at cycle 30.
    loop_en = 1'b1;
    start_play();
    for (int c = 1; c <= 31; c++) begin
      if (Legato) e_gate = (c >= 3 && c <= 10) || (c >= 19 && c <= 30);
      else        e_gate = (c >= 3 && c <= 8) || (c >= 19 && c <= 24) || (c >= 29 && c <= 30);
      e_note = (c < 3) ? 7'd72 : (c < 19) ? 7'd76 : (c < 29) ? 7'd72 : 7'd76;
      e_addr = (c < 9) ? 9'd0 : (c < 17) ? 9'd1 : (c < 25) ? 9'd2 : (c < 27) ? 9'd3 : 9'd0;
      check("loop_strobe", 32'(strobe), 32'(c == 3 || c == 11 || c == 19 || c == 29));
      check("loop_gate", 32'(gate), 32'(e_gate));
      check("loop_note", 32'(note), 32'(e_note));
      check("loop_addr", 32'(rom_if.rom_addr), 32'(e_addr));
      check("loop_done", 32'(done), 32'(0));
      check("loop_playing", 32'(playing), 32'(c <= 30));
      if (c == 30) stop = 1'b1;
      tick();
      stop = 1'b0;
    end

    // Replay after stop starts again at address 0.
    loop_en = 1'b0;
    start_play();
    check("replay_addr", 32'(rom_if.rom_addr), 32'(0));
    check("replay_playing", 32'(playing), 32'(1));
    tick(); tick();
    check("replay_strobe", 32'(strobe), 32'(1));
    check("replay_note", 32'(note), 32'(76));
    check("replay_gate", 32'(gate), 32'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("replay_stop_playing", 32'(playing), 32'(0));
    check("replay_stop_gate", 32'(gate), 32'(0));
    check("replay_stop_done", 32'(done), 32'(0));

    // Two equal notes: articulation gap, then reset during HOLD at cycle 13.
    mem[0] = 8'd72; mem[1] = 8'd72; mem[2] = 8'd0;
    tick();
    start_play();
    for (int c = 1; c <= 14; c++) begin
      if (c == 14)     e_gate = 1'b0;
      else if (Legato) e_gate = (c >= 3);
      else             e_gate = (c >= 3 && c <= 8) || (c >= 11);
      e_note = (c == 14) ? 7'd0 : (c < 3) ? 7'd76 : 7'd72;
      e_addr = (c < 9 || c == 14) ? 9'd0 : 9'd1;
      check("gap_gate", 32'(gate), 32'(e_gate));
      check("gap_note", 32'(note), 32'(e_note));
      check("gap_addr", 32'(rom_if.rom_addr), 32'(e_addr));
      check("gap_strobe", 32'(strobe), 32'(c == 3 || c == 11));
      check("gap_playing", 32'(playing), 32'(c <= 13));
      check("gap_done", 32'(done), 32'(0));
      if (c == 13) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    // Start and stop together while idle.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_playing", 32'(playing), 32'(0));
    check("ss_addr", 32'(rom_if.rom_addr), 32'(0));
    tick();
    check("ss_playing2", 32'(playing), 32'(0));
    check("ss_strobe", 32'(strobe), 32'(0));

    // No end code: run past the address wrap.
    for (int i = 0; i < 510; i++) mem[i] = 8'((i % 100) + 1);
    mem[510] = 8'd200;
    mem[511] = 8'd255;
    tick();
    strobes = 0;
    start_play();
    run_until(3 + 8 * 511);
    check("wrap_511_addr", 32'(rom_if.rom_addr), 32'(511));
    check("wrap_511_strobe", 32'(strobe), 32'(1));
    check("wrap_511_gate", 32'(gate), 32'(0));
    check("wrap_511_note", 32'(note), 32'(10));
    run_until(3 + 8 * 512);
    check("wrap_0_addr", 32'(rom_if.rom_addr), 32'(0));
    check("wrap_0_strobe", 32'(strobe), 32'(1));
    check("wrap_0_note", 32'(note), 32'(1));
    check("wrap_0_gate", 32'(gate), 32'(1));
    check("wrap_0_playing", 32'(playing), 32'(1));
    run_until(3 + 8 * 513);
    check("wrap_1_addr", 32'(rom_if.rom_addr), 32'(1));
    check("wrap_1_note", 32'(note), 32'(2));
    check("wrap_strobe_count", 32'(strobes), 32'(514));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wrap_stop_playing", 32'(playing), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Playback controller directly upstream of the registered note ROM: drives the ROM address and consumes its 8-bit note codes.
- Steps through the tune at a fixed step rate and converts each code into a held MIDI note plus gate for the downstream tone generator.
- Treats code 255 as a rest and code 0 as end-of-tune; looping is optional at run time.

Parameters:
- TICK_DIV, 6250000, clock cycles per sequencer step (8 steps/s at 50 MHz); must be >= GAP_CYCLES+4.
- GAP_CYCLES, 2, cycles of gate-low articulation at the end of each sounding step.
- ADDR_W, 9, ROM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin playback from address 0; ignored while playing.
- stop  in  1  abort playback; has priority over start.
- loop_en  in  1  1 = restart at address 0 on end code; 0 = stop at end code.
- rom_addr  out  ADDR_W  address to the note ROM (registered).
- rom_note  in  8  ROM data; valid one cycle after rom_addr changes.
- note  out  7  current MIDI note number, registered.
- gate  out  1  1 = note sounding.
- step_strobe  out  1  one-cycle pulse when note/gate take a new step's value.
- playing  out  1  high from first FETCH until return to IDLE.
- done  out  1  one-cycle pulse on natural end (end code with loop_en=0).

Behaviour:
- Reset: rom_addr=0, note=0, gate=0, step_strobe=0, playing=0, done=0, state IDLE, step counter 0. Reset mid-play aborts immediately with the same values; no done pulse.
- States: IDLE, FETCH, EVAL, HOLD.
- IDLE: when start=1 and stop=0 -> FETCH, rom_addr=0, playing=1.
- FETCH (1 cycle): rom_addr stable; the ROM registers it at this edge.
- EVAL (1 cycle): samples rom_note.
  - code 1..127: note<=code[6:0], gate<=1, step_strobe pulse, -> HOLD.
  - code 255 or 128..254: rest; gate<=0, note holds its previous value, step_strobe pulse, -> HOLD.
  - code 0, loop_en=1: rom_addr<=0, -> FETCH; no strobe, gate and note unchanged.
  - code 0, loop_en=0: gate<=0, playing<=0, done pulse, -> IDLE.
- HOLD:
  - Step counter counts such that consecutive FETCH entries are exactly TICK_DIV cycles apart.
  - When cycles remaining before the next FETCH <= GAP_CYCLES: gate<=0.
  - On expiry: rom_addr<=rom_addr+1 (wraps 2^ADDR_W-1 -> 0), -> FETCH.
- Timing: start sampled at cycle 0; FETCH in cycle 1; EVAL in cycle 2; note/gate/step_strobe visible in cycle 3.
- Loop restart adds a 2-cycle step-period stretch; no other jitter.
- stop=1 in any state: next cycle IDLE, gate=0, playing=0, no done pulse; note and rom_addr hold their values.
- start while playing is ignored. start and stop in the same cycle: stop wins.
- done and step_strobe are never high in the same cycle.

Optional Feature:
- Macro: NOTE_SEQ_LEGATO_EN.
- Defined: the GAP_CYCLES gate drop is suppressed. Gate stays continuously high across consecutive sounding steps and falls only on a rest, end, or stop.
- Undefined: articulation gap applies as above.

Test Plan:
- TICK_DIV=8, GAP=2, ROM stub [0]=76, [1]=255, [2]=72, [3]=0, loop_en=0; pulse start -> step_strobe in cycles 3, 11, 19; note=76 with gate high in cycles 3-8; gate low in cycles 9-18 (rest), note still 76; note=72 in cycle 19; done pulse once, in cycle 26; playing low afterwards.
- Same ROM, loop_en=1 -> after the end code, rom_addr returns to 0 and note=76 reappears 10 cycles after the last step's strobe; playing stays 1 and done never pulses.
- Stub [0]=72, [1]=72 -> gate low for exactly 2 cycles between the two steps. With NOTE_SEQ_LEGATO_EN defined, gate stays high throughout.
- Assert stop mid-HOLD at a sounding step -> next cycle gate=0, playing=0, no done pulse; a later start replays from address 0.
- ROM stub with no 0 code; run 2^ADDR_W+2 steps -> rom_addr wraps 511 -> 0 and playback continues.
- Assert rst during HOLD -> all outputs return to reset values on the next edge; start and stop together while IDLE -> stays IDLE.
